// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction-memory responder: default geometry,
// fetch latency and the controller state encoding.
package instr_mem_pkg;

    localparam int DEPTH_BYTES_DEF  = 1024;
    localparam int ADDR_W_DEF       = 10;
    localparam int READ_LATENCY_DEF = 3;
    localparam int WORD_W           = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/instr_byte_ram.sv
// Byte-wide instruction store: one synchronous write port and four combinational
// read taps forming a little-endian word at rd_addr..rd_addr+3 (wrapping at the top).
module instr_byte_ram
    import instr_mem_pkg::*;
#(
    parameter int DEPTH  = DEPTH_BYTES_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_word
);

    logic [7:0]        mem_r [0:DEPTH-1];
    logic [ADDR_W-1:0] tap1_s;
    logic [ADDR_W-1:0] tap2_s;
    logic [ADDR_W-1:0] tap3_s;

    // Byte write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read taps wrap naturally through ADDR_W-bit arithmetic.
    always_comb begin
        tap1_s  = rd_addr + ADDR_W'(1);
        tap2_s  = rd_addr + ADDR_W'(2);
        tap3_s  = rd_addr + ADDR_W'(3);
        rd_word = {mem_r[tap3_s], mem_r[tap2_s], mem_r[tap1_s], mem_r[rd_addr]};
    end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction-memory responder for the CPU fetch port: byte loader, tagged
// output word register and a fixed-latency fetch FSM that drives BUSYWAIT.
module instr_mem_ctrl
    import instr_mem_pkg::*;
#(
    parameter int DEPTH_BYTES  = DEPTH_BYTES_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int READ_LATENCY = READ_LATENCY_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       PC,
    output logic [WORD_W-1:0] INSTRUCTION,
    output logic              BUSYWAIT,
    input  logic              LOAD_START,
    input  logic              LOAD_EN,
    input  logic [7:0]        LOAD_DATA,
    output logic              LOADING
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);

    state_e            state_r;
    state_e            state_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] fetch_addr_r;
    logic [ADDR_W-1:0] served_pc_r;
    logic              valid_r;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [WORD_W-1:0] instr_r;
    logic              loading_r;
    logic [ADDR_W-1:0] pc_idx_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [WORD_W-1:0] rd_word_s;
    logic              miss_s;
    logic              fetch_start_s;
    logic              fetch_done_s;
    logic              pc_unused_s;

    assign pc_unused_s = ^PC[31:ADDR_W];

    instr_byte_ram #(
        .DEPTH  (DEPTH_BYTES),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (CLK),
        .wr_en   (LOAD_EN),
        .wr_addr (wr_addr_s),
        .wr_data (LOAD_DATA),
        .rd_addr (fetch_addr_r),
        .rd_word (rd_word_s)
    );

    // Hit/miss tagging, loader addressing and next-state selection.
    always_comb begin
        pc_idx_s      = PC[ADDR_W-1:0];
        miss_s        = !valid_r || (pc_idx_s != served_pc_r);
        wr_addr_s     = LOAD_START ? {ADDR_W{1'b0}} : wr_ptr_r;
        fetch_start_s = (state_r == ST_IDLE) && !LOAD_EN && miss_s;
        fetch_done_s  = (state_r == ST_FETCH) && !LOAD_EN && (cnt_r == {CNT_W{1'b0}});
        state_nx_s    = state_r;
        case (state_r)
            ST_IDLE: begin
                if (LOAD_EN)     state_nx_s = ST_LOAD;
                else if (miss_s) state_nx_s = ST_FETCH;
                else             state_nx_s = ST_IDLE;
            end
            ST_FETCH: begin
                // A load always wins; the pending fetch is simply dropped.
                if (LOAD_EN)           state_nx_s = ST_LOAD;
                else if (fetch_done_s) state_nx_s = ST_IDLE;
                else                   state_nx_s = ST_FETCH;
            end
            ST_LOAD: begin
                if (LOAD_EN) state_nx_s = ST_LOAD;
                else         state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Stall in the same cycle the PC moves, and for the whole of any fetch or load.
    assign BUSYWAIT    = (state_r != ST_IDLE) || miss_s;
    assign INSTRUCTION = instr_r;
    assign LOADING     = loading_r;

    // Controller state, latency counter, write pointer and served-word tag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            fetch_addr_r <= {ADDR_W{1'b0}};
            served_pc_r  <= {ADDR_W{1'b0}};
            valid_r      <= 1'b0;
            wr_ptr_r     <= {ADDR_W{1'b0}};
            instr_r      <= {WORD_W{1'b0}};
            loading_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            loading_r <= (state_nx_s == ST_LOAD);
            if (LOAD_EN) begin
                wr_ptr_r <= wr_addr_s + ADDR_W'(1);
            end else if (LOAD_START) begin
                wr_ptr_r <= {ADDR_W{1'b0}};
            end
            if (fetch_start_s) begin
                fetch_addr_r <= pc_idx_s;
                cnt_r        <= CNT_W'(READ_LATENCY - 1);
            end else if ((state_r == ST_FETCH) && (cnt_r != {CNT_W{1'b0}})) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
            // Any write or end of load invalidates the word so stale data is never served.
            if (LOAD_EN || (state_r == ST_LOAD)) begin
                valid_r <= 1'b0;
            end else if (fetch_done_s) begin
                valid_r     <= 1'b1;
                served_pc_r <= fetch_addr_r;
                instr_r     <= rd_word_s;
            end
        end
    end

endmodule
